// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default timing values,
// used by both the host master and the slave side.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } spi_state_t;

  // sys_clk cycles per sclk half-period
  localparam int SPI_CLK_DIV_DEFAULT    = 10;
  // minimum ss-low sys_clk cycles between consecutive bytes
  localparam int SPI_GAP_CYCLES_DEFAULT = 20;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period divider: one-cycle tick every CLK_DIV cycles while enabled,
// counter held at zero while disabled so each enable starts a fresh period.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] TERMINAL = 8'(CLK_DIV - 1);

  logic [7:0] cnt_reg;

  // Count 0..CLK_DIV-1 while enabled; restart from zero when disabled.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (!en || cnt_reg == TERMINAL) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign tick = en && (cnt_reg == TERMINAL);

endmodule

// File: rtl/spi_host_master.sv
// SPI host master, mode 0 (sclk idle low, sample on rising, shift on
// falling), one byte per transfer, active-high slave select.
module spi_host_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = SPI_CLK_DIV_DEFAULT,
  parameter int GAP_CYCLES = SPI_GAP_CYCLES_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  // The IDLE cycle that accepts the next byte also has ss low, so GAP only
  // needs GAP_CYCLES-1 cycles (but always at least one) for the ss-low
  // window between bytes to be GAP_CYCLES long.
  localparam logic [8:0] GAP_LIMIT = 9'(GAP_CYCLES);

  spi_state_t state_reg, state_next;

  logic       tick;
  logic       tick_en;
  logic       accept;
  logic       shift_tick;
  logic       rise_evt;
  logic       fall_evt;
  logic       last_fall;
  logic       gap_done;

  logic [2:0] bit_cnt_reg;
  logic [7:0] tx_shift_reg;
  logic [7:0] rx_shift_reg;
  logic [7:0] gap_cnt_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       ss_reg;
  logic       sclk_reg;
  logic       mosi_reg;

  assign tx_ready   = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign tick_en    = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT);
  assign accept     = tx_ready && tx_valid;
  assign shift_tick = (state_reg == ST_SHIFT) && tick;
  assign rise_evt   = shift_tick && !sclk_reg;
  assign fall_evt   = shift_tick && sclk_reg;
  assign last_fall  = fall_evt && (bit_cnt_reg == 3'd7);
  assign gap_done   = (state_reg == ST_GAP) &&
                      (({1'b0, gap_cnt_reg} + 9'd2) >= GAP_LIMIT);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .sys_clk(sys_clk),
    .rst    (rst),
    .en     (tick_en),
    .tick   (tick)
  );

  // FSM state register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept)    state_next = ST_SETUP;
      ST_SETUP: if (tick)      state_next = ST_SHIFT;
      ST_SHIFT: if (last_fall) state_next = ST_GAP;
      ST_GAP:   if (gap_done)  state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // Serial pins and transmit shifter: load on accept, advance on falling edges.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ss_reg       <= 1'b0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      tx_shift_reg <= '0;
      bit_cnt_reg  <= '0;
    end else if (accept) begin
      ss_reg       <= 1'b1;
      mosi_reg     <= tx_data[7];
      tx_shift_reg <= tx_data;
      bit_cnt_reg  <= '0;
    end else if (rise_evt) begin
      sclk_reg <= 1'b1;
    end else if (last_fall) begin
      ss_reg   <= 1'b0;
      sclk_reg <= 1'b0;
      mosi_reg <= 1'b0;
    end else if (fall_evt) begin
      sclk_reg     <= 1'b0;
      mosi_reg     <= tx_shift_reg[6];
      tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
      bit_cnt_reg  <= bit_cnt_reg + 3'd1;
    end
  end

  // Receive path: sample miso on rising edges, publish after the last falling edge.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_valid_reg <= last_fall;
      if (rise_evt) begin
        rx_shift_reg <= {rx_shift_reg[6:0], miso};
      end
      if (last_fall) begin
        rx_data_reg <= rx_shift_reg;
      end
    end
  end

  // Inter-byte gap counter, cleared whenever the block is outside GAP.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      gap_cnt_reg <= '0;
    end else if (state_reg == ST_GAP) begin
      gap_cnt_reg <= gap_cnt_reg + 8'd1;
    end else begin
      gap_cnt_reg <= '0;
    end
  end

  assign ss       = ss_reg;
  assign sclk     = sclk_reg;
  assign mosi     = mosi_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: two instances (default timing, and CLK_DIV=2 /
// GAP_CYCLES=1), a per-cycle timing model, a simple mode-0 slave per
// instance, and directed transfers with hand-computed expectations.
module tb_spi_host_master;

  localparam int D0 = 10;
  localparam int G0 = 20;
  localparam int D1 = 2;
  localparam int G1 = 1;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b0;
  logic [1:0] tx_valid = '0;
  logic [7:0] tx_data [2];
  logic [1:0] tx_ready;
  logic [7:0] rx_data [2];
  logic [1:0] rx_valid;
  logic [1:0] busy;
  logic [1:0] ss;
  logic [1:0] sclk;
  logic [1:0] mosi;
  logic [1:0] miso = '0;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 sys_clk = ~sys_clk;

  spi_host_master #(.CLK_DIV(D0), .GAP_CYCLES(G0)) dut0 (
    .sys_clk(sys_clk), .rst(rst),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .busy(busy[0]),
    .ss(ss[0]), .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_host_master #(.CLK_DIV(D1), .GAP_CYCLES(G1)) dut1 (
    .sys_clk(sys_clk), .rst(rst),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .busy(busy[1]),
    .ss(ss[1]), .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_n counts cycles since the accepting edge (1 = first ss-high cycle).
  // Byte frame: D setup cycles, then 16 half-periods of D cycles with sclk
  // low, high, low, ...; ss drops on the edge after 17*D cycles.
  bit         m_act [2] = '{0, 0};
  int         m_n   [2] = '{0, 0};
  logic [7:0] m_tx  [2] = '{8'h00, 8'h00};
  logic [7:0] m_slv [2] = '{8'h00, 8'h00};
  logic [7:0] m_rx  [2] = '{8'h00, 8'h00};
  logic [7:0] slv_byte [2] = '{8'h00, 8'h00};

  typedef struct packed {
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic       rxv;
    logic       rdy;
    logic [7:0] rx;
  } exp_t;

  function automatic int divv(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  // First cycle the next byte may be accepted: ss-low window of GAP cycles,
  // counting the accepting cycle, with never less than one gap cycle.
  function automatic int idle_n(input int i);
    int g;
    g = (i == 0) ? G0 : G1;
    return 17 * divv(i) + 1 + ((g > 1) ? g - 1 : 1);
  endfunction

  function automatic bit m_ready(input int i);
    return !m_act[i] || (m_n[i] >= idle_n(i));
  endfunction

  function automatic exp_t expect_of(input int i);
    exp_t e;
    int d, n, q, k;
    d = divv(i);
    n = m_n[i];
    e = '0;
    e.rx  = m_rx[i];
    e.rdy = m_ready(i);
    if (m_act[i]) begin
      if (n <= 17 * d) begin
        e.ss = 1'b1;
        k = 0;
        if (n > d) begin
          q = (n - d - 1) / d;
          e.sclk = (q % 2 == 1);
          k = q / 2;
        end
        e.mosi = m_tx[i][7 - k];
      end
      e.rxv = (n == 17 * d + 1);
    end
    return e;
  endfunction

  // Model update on every clock; reset clears it immediately.
  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0;
        m_n[i]   = 0;
        m_rx[i]  = 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit rdy;
        rdy = m_ready(i);
        if (m_act[i]) begin
          m_n[i]++;
          if (m_n[i] == 17 * divv(i) + 1) m_rx[i] = m_slv[i];
        end
        if (rdy && tx_valid[i]) begin
          m_act[i] = 1;
          m_n[i]   = 1;
          m_tx[i]  = tx_data[i];
          m_slv[i] = slv_byte[i];
        end
      end
    end
  end

  // ---------------- compare, recorder and slave ----------------
  logic       prev_ss   [2] = '{1'b0, 1'b0};
  logic       prev_sclk [2] = '{1'b0, 1'b0};
  logic [7:0] slv_sh    [2] = '{8'h00, 8'h00};
  logic [7:0] bits      [2] = '{8'h00, 8'h00};
  int ss_len [2] = '{0, 0};
  int last_ss_len [2] = '{0, 0};
  int low_len [2] = '{0, 0};
  int last_gap [2] = '{0, 0};
  int rises [2] = '{0, 0};
  int rises_out [2] = '{0, 0};
  int rxv_cnt [2] = '{0, 0};
  int xfers [2] = '{0, 0};
  int mosi_hi [2] = '{0, 0};

  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e = expect_of(i);
      chk("ss",       i, {7'd0, ss[i]},       {7'd0, e.ss});
      chk("sclk",     i, {7'd0, sclk[i]},     {7'd0, e.sclk});
      chk("mosi",     i, {7'd0, mosi[i]},     {7'd0, e.mosi});
      chk("rx_valid", i, {7'd0, rx_valid[i]}, {7'd0, e.rxv});
      chk("tx_ready", i, {7'd0, tx_ready[i]}, {7'd0, e.rdy});
      chk("busy",     i, {7'd0, busy[i]},     {7'd0, !e.rdy});
      chk("rx_data",  i, rx_data[i],          e.rx);
      // recorder
      if (ss[i]) begin
        if (!prev_ss[i]) begin
          xfers[i]++;
          last_gap[i] = low_len[i];
          ss_len[i]   = 0;
        end
        ss_len[i]++;
        if (mosi[i]) mosi_hi[i]++;
      end else begin
        if (prev_ss[i]) begin
          last_ss_len[i] = ss_len[i];
          low_len[i]     = 0;
        end
        low_len[i]++;
      end
      if (sclk[i] && !prev_sclk[i]) begin
        rises[i]++;
        bits[i] = {bits[i][6:0], mosi[i]};
        if (!ss[i]) rises_out[i]++;
      end
      if (rx_valid[i]) rxv_cnt[i]++;
      // mode-0 slave: present MSB on select, shift on sclk falling
      if (ss[i] && !prev_ss[i]) slv_sh[i] = slv_byte[i];
      else if (!sclk[i] && prev_sclk[i]) slv_sh[i] = {slv_sh[i][6:0], 1'b0};
      miso[i]      = slv_sh[i][7];
      prev_ss[i]   = ss[i];
      prev_sclk[i] = sclk[i];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input int i);
    int budget;
    budget = 2000;
    while (tx_ready[i] !== 1'b1 && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    chk("ready_wait", i, {7'd0, tx_ready[i]}, 8'd1);
  endtask

  task automatic send(input int i, input logic [7:0] b, input logic [7:0] s);
    slv_byte[i] = s;
    @(negedge sys_clk);
    wait_ready(i);
    tx_data[i]  = b;
    tx_valid[i] = 1'b1;
    @(posedge sys_clk);
    #1 tx_valid[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [7:0] bseq [4];
    logic [7:0] sseq [4];
    int r0, v0, x0, h0, budget;
    bseq = '{8'h80, 8'h00, 8'h9B, 8'hAA};
    sseq = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_data[0] = 8'h00;
    tx_data[1] = 8'h00;

    #1 rst = 1'b1;
    idle(3);
    chk("rst_rx_data", 0, rx_data[0], 8'h00);
    chk("rst_ready",   0, {7'd0, tx_ready[0]}, 8'd1);
    chk("rst_ss",      0, {7'd0, ss[0]}, 8'd0);
    rst = 1'b0;
    @(posedge sys_clk);
    #1 chk("ready_after_rst", 0, {7'd0, tx_ready[0]}, 8'd1);

    // 0x80 with miso all ones
    r0 = rises[0]; v0 = rxv_cnt[0];
    send(0, 8'h80, 8'hFF);
    idle(200);
    $display("xfer dut0 tx=80 rx=%h", rx_data[0]);
    chk("t1_bits",   0, bits[0], 8'h80);
    chk("t1_rx",     0, rx_data[0], 8'hFF);
    chk("t1_rises",  0, 8'(rises[0] - r0), 8'd8);
    chk("t1_rxv",    0, 8'(rxv_cnt[0] - v0), 8'd1);
    chk("t1_ss_len", 0, 8'(last_ss_len[0]), 8'd170);

    // 0xAA against a slave returning 0x5A
    r0 = rises[0]; h0 = rises_out[0];
    send(0, 8'hAA, 8'h5A);
    idle(200);
    $display("xfer dut0 tx=AA rx=%h", rx_data[0]);
    chk("t2_rx",        0, rx_data[0], 8'h5A);
    chk("t2_bits",      0, bits[0], 8'hAA);
    chk("t2_rises",     0, 8'(rises[0] - r0), 8'd8);
    chk("t2_rises_out", 0, 8'(rises_out[0] - h0), 8'd0);

    // back-to-back with tx_valid held
    x0 = xfers[0];
    for (int j = 0; j < 4; j++) begin
      tx_data[0]  = bseq[j];
      slv_byte[0] = sseq[j];
      tx_valid[0] = 1'b1;
      wait_ready(0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      #1;
      if (j > 0) begin
        $display("xfer dut0 tx=%h gap=%0d", bseq[j - 1], last_gap[0]);
        chk("t3_gap",  0, 8'(last_gap[0]), 8'd20);
        chk("t3_bits", 0, bits[0], bseq[j - 1]);
      end
    end
    tx_valid[0] = 1'b0;
    idle(200);
    $display("xfer dut0 tx=AA rx=%h", rx_data[0]);
    chk("t3_bits_last", 0, bits[0], 8'hAA);
    chk("t3_rx_last",   0, rx_data[0], 8'h44);
    chk("t3_xfers",     0, 8'(xfers[0] - x0), 8'd4);

    // reset after the 4th rising edge of 0x3C
    r0 = rises[0]; v0 = rxv_cnt[0];
    send(0, 8'h3C, 8'hA5);
    budget = 500;
    while ((rises[0] - r0) < 4 && budget > 0) begin
      @(negedge sys_clk);
      #1 budget--;
    end
    chk("t4_reach_rise4", 0, 8'(rises[0] - r0), 8'd4);
    #2 rst = 1'b1;
    #1;
    $display("xfer dut0 tx=3C aborted by reset");
    chk("t4_ss",   0, {7'd0, ss[0]},   8'd0);
    chk("t4_sclk", 0, {7'd0, sclk[0]}, 8'd0);
    chk("t4_mosi", 0, {7'd0, mosi[0]}, 8'd0);
    chk("t4_busy", 0, {7'd0, busy[0]}, 8'd0);
    idle(2);
    #2 rst = 1'b0;
    @(posedge sys_clk);
    #1 chk("t4_ready", 0, {7'd0, tx_ready[0]}, 8'd1);
    idle(200);
    chk("t4_no_rxv", 0, 8'(rxv_cnt[0] - v0), 8'd0);
    send(0, 8'hC3, 8'h96);
    idle(200);
    $display("xfer dut0 tx=C3 rx=%h", rx_data[0]);
    chk("t4_bits", 0, bits[0], 8'hC3);
    chk("t4_rx",   0, rx_data[0], 8'h96);
    chk("t4_rxv",  0, 8'(rxv_cnt[0] - v0), 8'd1);

    // fast instance: CLK_DIV=2, GAP_CYCLES=1
    h0 = mosi_hi[1];
    send(1, 8'h01, 8'hC6);
    idle(60);
    $display("xfer dut1 tx=01 rx=%h", rx_data[1]);
    chk("t5_ss_len",  1, 8'(last_ss_len[1]), 8'd34);
    chk("t5_mosi_hi", 1, 8'(mosi_hi[1] - h0), 8'd4);
    chk("t5_bits",    1, bits[1], 8'h01);
    chk("t5_rx",      1, rx_data[1], 8'hC6);

    // tx_data/tx_valid activity during SHIFT of 0x0F is ignored
    r0 = rises[0]; x0 = xfers[0];
    send(0, 8'h0F, 8'h3C);
    budget = 500;
    while ((rises[0] - r0) < 2 && budget > 0) begin
      @(negedge sys_clk);
      #1 budget--;
    end
    tx_data[0]  = 8'hF0;
    tx_valid[0] = 1'b1;
    idle(3);
    tx_valid[0] = 1'b0;
    idle(250);
    $display("xfer dut0 tx=0F rx=%h", rx_data[0]);
    chk("t6_bits",  0, bits[0], 8'h0F);
    chk("t6_xfers", 0, 8'(xfers[0] - x0), 8'd1);
    chk("t6_rx",    0, rx_data[0], 8'h3C);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
